// File: rtl/ex_mem_stage_pkg.sv
// Shared constants for the EX/MEM pipeline register: ALU op codes and NZCV bit positions.
package ex_mem_stage_pkg;

    localparam logic [2:0] AluPassB = 3'b000;
    localparam logic [2:0] AluAdd   = 3'b010;
    localparam logic [2:0] AluSub   = 3'b011;
    localparam logic [2:0] AluAnd   = 3'b100;
    localparam logic [2:0] AluOr    = 3'b101;
    localparam logic [2:0] AluXor   = 3'b110;

    localparam int unsigned FlagN = 3;
    localparam int unsigned FlagZ = 2;
    localparam int unsigned FlagC = 1;
    localparam int unsigned FlagV = 0;

    // Only add/sub produce meaningful carry and overflow.
    function automatic logic is_arith(input logic [2:0] cntrl);
        return (cntrl == AluAdd) || (cntrl == AluSub);
    endfunction

endpackage

// File: rtl/ex_mem_stage_flag_gen.sv
// Computes the candidate NZCV value from the current ALU result and status bits.
module ex_mem_stage_flag_gen
    import ex_mem_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] result_i,
    input  logic [2:0]       cntrl_i,
    input  logic             carry_i,
    input  logic             ovf_i,
    output logic [3:0]       nzcv_o
);

    // N/Z from the result, C/V passed through only for add/sub.
    always_comb begin
        nzcv_o        = 4'b0000;
        nzcv_o[FlagN] = result_i[WIDTH-1];
        nzcv_o[FlagZ] = (result_i == '0);
        nzcv_o[FlagC] = is_arith(cntrl_i) ? carry_i : 1'b0;
        nzcv_o[FlagV] = is_arith(cntrl_i) ? ovf_i : 1'b0;
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with NZCV flag register and retired-op counter.
// Optional macro EX_FLAG_BYPASS_EN: forward pending flag update onto flags_nzcv combinationally.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_result,
    input  logic [2:0]       in_cntrl,
    input  logic             in_carry,
    input  logic             in_ovf,
    input  logic             in_setflags,
    input  logic [4:0]       in_rd,
    input  logic             in_regwrite,
    input  logic             in_memread,
    input  logic             in_memwrite,
    input  logic [WIDTH-1:0] in_wdata,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic             out_regwrite,
    output logic             out_memread,
    output logic             out_memwrite,
    output logic [WIDTH-1:0] out_result,
    output logic [WIDTH-1:0] out_wdata,
    output logic [4:0]       out_rd,
    output logic [3:0]       flags_nzcv,
    output logic             zero_now,
    output logic [CNT_W-1:0] retired_cnt
);

    logic             valid_q, valid_d;
    logic             regwrite_q, regwrite_d;
    logic             memread_q, memread_d;
    logic             memwrite_q, memwrite_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [4:0]       rd_q, rd_d;
    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       capture;
    logic       flag_upd;
    logic [3:0] flags_new;

    assign capture  = !flush && !stall;
    assign flag_upd = capture && in_valid && in_setflags;

    ex_mem_stage_flag_gen #(
        .WIDTH (WIDTH)
    ) flag_gen (
        .result_i (in_result),
        .cntrl_i  (in_cntrl),
        .carry_i  (in_carry),
        .ovf_i    (in_ovf),
        .nzcv_o   (flags_new)
    );

    // Next-state: flush clears control only, stall holds everything, else capture.
    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        result_d   = result_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        flags_d    = flags_q;
        cnt_d      = cnt_q;
        if (flush) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
        end else if (!stall) begin
            valid_d    = in_valid;
            regwrite_d = in_regwrite && in_valid;
            memread_d  = in_memread && in_valid;
            memwrite_d = in_memwrite && in_valid;
            result_d   = in_result;
            wdata_d    = in_wdata;
            rd_d       = in_rd;
            if (in_valid) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (flag_upd) begin
                flags_d = flags_new;
            end
        end
    end

    // Stage registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            result_q   <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            flags_q    <= '0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            result_q   <= result_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            flags_q    <= flags_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_regwrite = regwrite_q;
    assign out_memread  = memread_q;
    assign out_memwrite = memwrite_q;
    assign out_result   = result_q;
    assign out_wdata    = wdata_q;
    assign out_rd       = rd_q;
    assign retired_cnt  = cnt_q;
    assign zero_now     = (in_result == '0);

`ifdef EX_FLAG_BYPASS_EN
    // Reset wins over the bypass so flags read 0 while reset is held.
    assign flags_nzcv = (flag_upd && !reset) ? flags_new : flags_q;
`else
    assign flags_nzcv = flags_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: reference model plus directed literal checks.
module tb_ex_mem_stage;

    localparam int unsigned W  = 64;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_carry, in_ovf, in_setflags;
    logic [W-1:0]  in_result, in_wdata;
    logic [2:0]    in_cntrl;
    logic [4:0]    in_rd;
    logic          in_regwrite, in_memread, in_memwrite, stall, flush;
    logic          out_valid, out_regwrite, out_memread, out_memwrite, zero_now;
    logic [W-1:0]  out_result, out_wdata;
    logic [4:0]    out_rd;
    logic [3:0]    flags_nzcv;
    logic [CW-1:0] retired_cnt;

    int vectors = 0;
    int fails   = 0;
    bit check_en = 1'b0;

    ex_mem_stage #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_result    (in_result),
        .in_cntrl     (in_cntrl),
        .in_carry     (in_carry),
        .in_ovf       (in_ovf),
        .in_setflags  (in_setflags),
        .in_rd        (in_rd),
        .in_regwrite  (in_regwrite),
        .in_memread   (in_memread),
        .in_memwrite  (in_memwrite),
        .in_wdata     (in_wdata),
        .stall        (stall),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_regwrite (out_regwrite),
        .out_memread  (out_memread),
        .out_memwrite (out_memwrite),
        .out_result   (out_result),
        .out_wdata    (out_wdata),
        .out_rd       (out_rd),
        .flags_nzcv   (flags_nzcv),
        .zero_now     (zero_now),
        .retired_cnt  (retired_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state: what the stage must be holding.
    logic          m_valid, m_rw, m_mr, m_mw;
    logic [W-1:0]  m_result, m_wdata;
    logic [4:0]    m_rd;
    logic [3:0]    m_flags;
    logic [CW-1:0] m_cnt;

    function automatic logic [3:0] calc_flags(input logic [W-1:0] res, input logic [2:0] op,
                                              input logic c, input logic o);
        logic arith;
        arith = (op == 3'd2) || (op == 3'd3);
        return {res[W-1], res == 64'd0, arith ? c : 1'b0, arith ? o : 1'b0};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0; m_rw <= 1'b0; m_mr <= 1'b0; m_mw <= 1'b0;
            m_result <= '0; m_wdata <= '0; m_rd <= '0; m_flags <= '0; m_cnt <= '0;
        end else if (flush) begin
            m_valid <= 1'b0; m_rw <= 1'b0; m_mr <= 1'b0; m_mw <= 1'b0;
        end else if (!stall) begin
            m_valid  <= in_valid;
            m_rw     <= in_valid & in_regwrite;
            m_mr     <= in_valid & in_memread;
            m_mw     <= in_valid & in_memwrite;
            m_result <= in_result;
            m_wdata  <= in_wdata;
            m_rd     <= in_rd;
            if (in_valid) m_cnt <= CW'((int'(m_cnt) + 1) % (1 << CW));
            if (in_valid && in_setflags)
                m_flags <= calc_flags(in_result, in_cntrl, in_carry, in_ovf);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        if (check_en && !reset) begin
            logic [3:0] exp_fl;
            exp_fl = m_flags;
`ifdef EX_FLAG_BYPASS_EN
            if (in_valid && in_setflags && !stall && !flush)
                exp_fl = calc_flags(in_result, in_cntrl, in_carry, in_ovf);
`endif
            chk("m_valid",    64'(out_valid),    64'(m_valid));
            chk("m_regwrite", 64'(out_regwrite), 64'(m_rw));
            chk("m_memread",  64'(out_memread),  64'(m_mr));
            chk("m_memwrite", 64'(out_memwrite), 64'(m_mw));
            chk("m_result",   out_result,        m_result);
            chk("m_wdata",    out_wdata,         m_wdata);
            chk("m_rd",       64'(out_rd),       64'(m_rd));
            chk("m_flags",    64'(flags_nzcv),   64'(exp_fl));
            chk("m_zero_now", 64'(zero_now),     64'(in_result == 64'd0));
            chk("m_cnt",      64'(retired_cnt),  64'(m_cnt));
        end
    end

    task automatic drive(input logic v, input logic [63:0] res, input logic [2:0] op,
                         input logic c, input logic o, input logic sf, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic mw, input logic [63:0] wd,
                         input logic st, input logic fl);
        in_valid = v; in_result = res; in_cntrl = op; in_carry = c; in_ovf = o;
        in_setflags = sf; in_rd = rd; in_regwrite = rw; in_memread = mr; in_memwrite = mw;
        in_wdata = wd; stall = st; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        drive(0, 64'd0, 3'd0, 0, 0, 0, 5'd0, 0, 0, 0, 64'd0, 0, 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        check_en = 1'b1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_flags", 64'(flags_nzcv), 64'd0);
        chk("rst_cnt",   64'(retired_cnt), 64'd0);

        // Basic capture
        drive(1, 64'h5, 3'd2, 0, 0, 0, 5'd3, 1, 0, 0, 64'hAA, 0, 0);
        tick();
        chk("cap_result", out_result, 64'h5);
        chk("cap_rd",     64'(out_rd), 64'd3);
        chk("cap_rw",     64'(out_regwrite), 64'd1);
        chk("cap_cnt",    64'(retired_cnt), 64'd1);

        // Flags: sub giving zero with carry, then and with MSB set
        drive(1, 64'h0, 3'b011, 1, 0, 1, 5'd4, 1, 0, 0, 64'h0, 0, 0);
        tick();
        chk("flags_sub", 64'(flags_nzcv), 64'b0110);
        drive(1, 64'h8000_0000_0000_0000, 3'b100, 1, 1, 1, 5'd4, 1, 0, 0, 64'h0, 0, 0);
        tick();
        chk("flags_and", 64'(flags_nzcv), 64'b1000);

        // Load, then invalid op with control bits set (must be gated)
        drive(1, 64'h1234, 3'd0, 0, 0, 0, 5'd7, 0, 1, 0, 64'hDEAD, 0, 0);
        tick();
        chk("ld_memread", 64'(out_memread), 64'd1);
        drive(0, 64'h77, 3'd0, 0, 0, 1, 5'd8, 1, 1, 1, 64'hBEEF, 0, 0);
        tick();
        chk("inv_valid", 64'(out_valid), 64'd0);
        chk("inv_mw",    64'(out_memwrite), 64'd0);
        chk("inv_data",  out_result, 64'h77);
        chk("inv_cnt",   64'(retired_cnt), 64'd4);

        // Stall and flush together: bubble, flags and count untouched, data held
        drive(1, 64'h0, 3'd2, 1, 1, 1, 5'd9, 1, 0, 1, 64'h0, 1, 1);
        tick();
        chk("sf_valid",  64'(out_valid), 64'd0);
        chk("sf_flags",  64'(flags_nzcv), 64'b1000);
        chk("sf_cnt",    64'(retired_cnt), 64'd4);
        chk("sf_result", out_result, 64'h77);

        // Stall alone for three cycles holds everything
        drive(1, 64'h55, 3'd0, 0, 0, 0, 5'd10, 1, 0, 0, 64'h66, 0, 0);
        tick();
        drive(1, 64'h99, 3'd2, 1, 1, 1, 5'd11, 0, 1, 1, 64'h0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_result", out_result, 64'h55);
            chk("stall_rd",     64'(out_rd), 64'd10);
            chk("stall_cnt",    64'(retired_cnt), 64'd5);
        end

        // Flag timing: add producing zero
        drive(1, 64'h0, 3'd2, 0, 0, 1, 5'd1, 1, 0, 0, 64'h0, 0, 0);
        #1;
`ifdef EX_FLAG_BYPASS_EN
        chk("bypass_same", 64'(flags_nzcv), 64'b0100);
`else
        chk("bypass_same", 64'(flags_nzcv), 64'b1000);
`endif
        tick();
        chk("bypass_next", 64'(flags_nzcv), 64'b0100);

        // Non-flag-setting op leaves flags alone
        drive(1, 64'hF000_0000_0000_0001, 3'b110, 0, 0, 0, 5'd12, 1, 0, 0, 64'h1, 0, 0);
        tick();
        chk("hold_flags", 64'(flags_nzcv), 64'b0100);

        // Asynchronous reset mid-cycle with a valid op in flight
        reset = 1'b1;
        #1;
        chk("arst_valid",  64'(out_valid), 64'd0);
        chk("arst_rw",     64'(out_regwrite), 64'd0);
        chk("arst_result", out_result, 64'd0);
        chk("arst_rd",     64'(out_rd), 64'd0);
        chk("arst_flags",  64'(flags_nzcv), 64'd0);
        chk("arst_cnt",    64'(retired_cnt), 64'd0);
        #1 reset = 1'b0;
        tick();
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_cnt",   64'(retired_cnt), 64'd1);

        // Counter wrap on a 4-bit counter
        reset = 1'b1;
        #1 reset = 1'b0;
        drive(1, 64'h3, 3'd0, 0, 0, 0, 5'd2, 1, 0, 0, 64'h0, 0, 0);
        repeat (15) tick();
        chk("wrap_15", 64'(retired_cnt), 64'd15);
        tick();
        chk("wrap_0",  64'(retired_cnt), 64'd0);

        drive(0, 64'd1, 3'd0, 0, 0, 0, 5'd0, 0, 0, 0, 64'd0, 0, 0);
        tick();
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
